// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter family.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int ARB_N_DEF  = 4;
    localparam int ARB_WW_DEF = 4;
    localparam int ARB_MAX_N  = 16;

    // Binary index of a one-hot vector; an all-zero input yields 0.
    function automatic logic [3:0] onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requester strictly after ptr (mod N) wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N   = ARB_N_DEF,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   win,
    output logic [IDW-1:0] win_id,
    output logic           any
);

    localparam int W2 = 2 * N;

    logic [W2-1:0] mask;
    logic [W2-1:0] masked;
    logic [W2-1:0] first;

    // Double the request vector, blank bits at or below ptr in the low copy,
    // isolate the lowest remaining bit, then fold the two halves together.
    always_comb begin
        mask   = ({W2{1'b1}} << ptr) << 1;
        masked = {req, req} & mask;
        first  = masked & (~masked + W2'(1));
        win    = first[N-1:0] | first[W2-1:N];
        any    = |req;
        win_id = IDW'(onehot_to_idx(ARB_MAX_N'(win)));
    end

endmodule

// File: rtl/wrr_burst_arb.sv
// Weighted round-robin arbiter: a grant holds for up to weight[i] beats, last, or req drop.
// Latency: 1 cycle from req sampled to registered gnt; back-to-back grants with no bubble.
// Backpressure: a granted requester stalls the burst by nothing; dropping req releases without using credit.
module wrr_burst_arb
    import arb_pkg::*;
#(
    parameter int N   = ARB_N_DEF,
    parameter int WW  = ARB_WW_DEF,
    parameter int IDW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    last,
    input  logic [N*WW-1:0] weight,
    output logic [N-1:0]    gnt,
    output logic            gnt_vld,
    output logic [IDW-1:0]  gnt_id,
    output logic [WW-1:0]   credit
);

    arb_state_e     state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           gnt_vld_q, gnt_vld_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [WW-1:0]  credit_q, credit_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic [N-1:0]   pick_win;
    logic [IDW-1:0] pick_id;
    logic           pick_any;

    logic [WW-1:0]  w_sel;
    logic [WW-1:0]  load_credit;
    logic           cur_req;
    logic           cur_last;
    logic           beat;
    logic           release_now;

    // ptr always equals the last granted index, so a releasing requester
    // automatically drops to lowest priority in the next pick.
    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .win    (pick_win),
        .win_id (pick_id),
        .any    (pick_any)
    );

    // Grant bookkeeping: weight of the candidate winner and release decision for the holder.
    always_comb begin
        w_sel       = weight[int'(pick_id)*WW +: WW];
        load_credit = (w_sel == '0) ? WW'(1) : w_sel;
        cur_req     = req[gnt_id_q];
        cur_last    = last[gnt_id_q];
        beat        = (state_q == ARB_GRANT) && cur_req;
        // A req drop releases without a beat; last or final credit release only on a beat.
        release_now = (state_q == ARB_GRANT) &&
                      (!cur_req || (beat && (cur_last || credit_q == WW'(1))));
    end

    // Next state: arbitrate when idle or releasing, otherwise burn one credit per beat.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_vld_d = gnt_vld_q;
        gnt_id_d  = gnt_id_q;
        credit_d  = credit_q;
        ptr_d     = ptr_q;
        if (state_q == ARB_IDLE || release_now) begin
            if (pick_any) begin
                state_d   = ARB_GRANT;
                gnt_d     = pick_win;
                gnt_vld_d = 1'b1;
                gnt_id_d  = pick_id;
                credit_d  = load_credit;
                ptr_d     = pick_id;
            end else begin
                state_d   = ARB_IDLE;
                gnt_d     = '0;
                gnt_vld_d = 1'b0;
                gnt_id_d  = '0;
                credit_d  = '0;
            end
        end else if (beat) begin
            credit_d = credit_q - WW'(1);
        end
    end

    // State registers; reset clears the grant immediately and favours requester 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            gnt_id_q  <= '0;
            credit_q  <= '0;
            ptr_q     <= IDW'(N - 1);
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_id_q  <= gnt_id_d;
            credit_q  <= credit_d;
            ptr_q     <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = gnt_vld_q;
    assign gnt_id  = gnt_id_q;
    assign credit  = credit_q;

endmodule

// File: tb/tb_wrr_burst_arb.sv
// Self-checking bench for wrr_burst_arb: directed vectors plus a queue-free grant model.
// Latency: model and DUT both update on the rising edge; outputs compared on the falling edge.
// Backpressure: stimulus drives req/last 1 ns after each rising edge.
module tb_wrr_burst_arb;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int IDW = 2;
    localparam logic [N*WW-1:0] W_STD  = 16'h1213; // w3..w0 = 1,2,1,3
    localparam logic [N*WW-1:0] W_ZERO = 16'h1203; // w1 = 0

    logic            clk = 1'b0;
    logic            rstn = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    last = '0;
    logic [N*WW-1:0] weight = W_STD;
    logic [N-1:0]    gnt;
    logic            gnt_vld;
    logic [IDW-1:0]  gnt_id;
    logic [WW-1:0]   credit;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model state: who holds the grant (-1 = nobody), beats left, last winner.
    int m_cur  = -1;
    int m_cred = 0;
    int m_ptr  = N - 1;
    int m_nxt;

    wrr_burst_arb #(.N(N), .WW(WW), .IDW(IDW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .last    (last),
        .weight  (weight),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id),
        .credit  (credit)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int wfield(input logic [N*WW-1:0] w, input int i);
        logic [WW-1:0] f;
        f = w[i*WW +: WW];
        return (f == 0) ? 1 : int'(f);
    endfunction

    // First requester after 'after', wrapping; -1 when nobody asks.
    function automatic int pick(input logic [N-1:0] r, input int after);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (after + k) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    // Behavioural model: keep the holder while it has credit to spare, else re-pick.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cur  = -1;
            m_cred = 0;
            m_ptr  = N - 1;
        end else if (m_cur >= 0 && req[m_cur] && !last[m_cur] && m_cred > 1) begin
            m_cred = m_cred - 1;
        end else begin
            if (m_cur >= 0) m_ptr = m_cur;
            m_nxt = pick(req, m_ptr);
            if (m_nxt < 0) begin
                m_cur  = -1;
                m_cred = 0;
            end else begin
                m_cur  = m_nxt;
                m_ptr  = m_nxt;
                m_cred = wfield(weight, m_nxt);
            end
        end
    end

    // Every falling edge: DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_gnt",    32'(gnt),     (m_cur < 0) ? 32'd0 : (32'd1 << m_cur));
            check("mdl_vld",    32'(gnt_vld), (m_cur < 0) ? 32'd0 : 32'd1);
            check("mdl_id",     32'(gnt_id),  (m_cur < 0) ? 32'd0 : 32'(m_cur));
            check("mdl_credit", 32'(credit),  32'(m_cred));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Literal expectation: grant vector and credit; id and valid follow from the vector.
    task automatic expect_out(input string nm, input logic [3:0] g, input logic [3:0] c);
        logic [31:0] id;
        id = 0;
        for (int i = 0; i < N; i++) if (g[i]) id = 32'(i);
        check({nm, "_gnt"},    32'(gnt),     32'(g));
        check({nm, "_vld"},    32'(gnt_vld), (g != 0) ? 32'd1 : 32'd0);
        check({nm, "_id"},     32'(gnt_id),  id);
        check({nm, "_credit"}, 32'(credit),  32'(c));
    endtask

    // Nibble i of gs/cs is the expected grant/credit after the (i+1)-th edge.
    task automatic chk_seq(input string nm, input int len, input logic [63:0] gs, input logic [63:0] cs);
        for (int i = 0; i < len; i++) begin
            step();
            expect_out(nm, gs[i*4 +: 4], cs[i*4 +: 4]);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req  = '0;
        last = '0;
        #1;
        expect_out("rst", 4'h0, 4'h0);
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected to end earlier", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        do_reset();
        chk_en = 1'b1;

        // 1: sole requester 0, weight 3 -> credit 3,2,1 repeating, grant never drops.
        req = 4'b0001;
        chk_seq("t1", 6, 64'h111111, 64'h123123);

        // 2: everyone asks -> 0 x3, 1 x1, 2 x2, 3 x1, repeating without gaps.
        do_reset();
        req = 4'b1111;
        chk_seq("t2", 14, 64'h84421118442111, 64'h11211231121123);

        // 3: last on requester 0's first beat hands over to 1, which then hands back.
        do_reset();
        req = 4'b0011;
        step();
        expect_out("t3a", 4'b0001, 4'd3);
        last = 4'b0001;
        step();
        expect_out("t3b", 4'b0010, 4'd1);
        last = 4'b0000;
        step();
        expect_out("t3c", 4'b0001, 4'd3);

        // 4: requester 2 drops after one beat; 3 takes over, then 2 returns with full credit.
        do_reset();
        req = 4'b0100;
        step();
        expect_out("t4a", 4'b0100, 4'd2);
        req = 4'b1100;
        step();
        expect_out("t4b", 4'b0100, 4'd1);
        req = 4'b1000;
        step();
        expect_out("t4c", 4'b1000, 4'd1);
        req = 4'b0100;
        step();
        expect_out("t4d", 4'b0100, 4'd2);

        // 5: zero weight behaves as one -> re-granted every cycle with credit 1.
        weight = W_ZERO;
        do_reset();
        req = 4'b0010;
        chk_seq("t5", 5, 64'h22222, 64'h11111);
        weight = W_STD;

        // 6: reset mid-burst clears outputs at once; afterwards 0, then 2, then 3.
        do_reset();
        req = 4'b1111;
        step();
        step();
        expect_out("t6pre", 4'b0001, 4'd2);
        #2;
        rstn = 1'b0;
        #1;
        expect_out("t6rst", 4'h0, 4'h0);
        req = 4'b1101;
        #2;
        rstn = 1'b1;
        chk_seq("t6", 6, 64'h844111, 64'h112123);

        req = 4'b0000;
        step();
        step();
        expect_out("t6idle", 4'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
